// File: rtl/sync_fifo_param_pkg.sv
// Shared helpers for the parametrised FIFO slice.
// Kept separate so tool flows without $clog2 can still size the pointers.
package sync_fifo_param_pkg;

   function automatic int fifo_clog2(input int value);
      int result = 0;
      int span = 1;
      while (span < value) begin
         span = span * 2;
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo_param_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module dual_port_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   output logic [DATA_WIDTH-1:0] r_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[w_addr] <= w_data;
      end
   end

   assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO of arbitrary depth with fill count, threshold flags,
// sticky error flags and selectable first-word-fall-through read.
module sync_fifo_param
   import sync_fifo_param_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 13,
   parameter  int AFULL_TH   = 11,
   parameter  int AEMPTY_TH  = 2,
   parameter  int FWFT       = 1,
   localparam int AW         = fifo_clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [AW:0]           count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   AFULL_CNT  = (AW+1)'(AFULL_TH);
   localparam logic [AW:0]   AEMPTY_CNT = (AW+1)'(AEMPTY_TH);

   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  wr_acc;
   logic                  rd_acc;

   assign full         = (count == DEPTH_CNT);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AFULL_CNT);
   assign almost_empty = (count <= AEMPTY_CNT);

   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   dual_port_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (AW)
   ) u_ram (
      .clk    (clk),
      .we     (wr_acc),
      .w_addr (wr_ptr),
      .w_data (wr_data),
      .r_addr (rd_ptr),
      .r_data (ram_rdata)
   );

   // Pointers wrap explicitly at DEPTH-1 because DEPTH need not be a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Setting takes priority over clr_err so an error in the clearing cycle is not lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rd_data  = ram_rdata;
         assign rd_valid = !empty;
      end else begin : g_registered
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               rd_data  <= '0;
               rd_valid <= 1'b0;
            end else begin
               rd_valid <= rd_acc;
               if (rd_acc) begin
                  rd_data <= ram_rdata;
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one FWFT and one registered-read
// instance share the same stimulus so both read modes are compared each step.
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic       clr_err;

   logic [7:0] fw_rd_data;
   logic       fw_rd_valid, fw_full, fw_empty, fw_afull, fw_aempty, fw_ovf, fw_udf;
   logic [4:0] fw_count;

   logic [7:0] rg_rd_data;
   logic       rg_rd_valid, rg_full, rg_empty, rg_afull, rg_aempty, rg_ovf, rg_udf;
   logic [4:0] rg_count;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(13), .AFULL_TH(11), .AEMPTY_TH(2), .FWFT(1)) dut (
      .clk (clk), .reset_n (reset_n), .wr_en (wr_en), .wr_data (wr_data), .rd_en (rd_en),
      .rd_data (fw_rd_data), .rd_valid (fw_rd_valid), .full (fw_full), .empty (fw_empty),
      .almost_full (fw_afull), .almost_empty (fw_aempty), .count (fw_count),
      .overflow (fw_ovf), .underflow (fw_udf), .clr_err (clr_err)
   );

   sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(13), .AFULL_TH(11), .AEMPTY_TH(2), .FWFT(0)) dut_reg (
      .clk (clk), .reset_n (reset_n), .wr_en (wr_en), .wr_data (wr_data), .rd_en (rd_en),
      .rd_data (rg_rd_data), .rd_valid (rg_rd_valid), .full (rg_full), .empty (rg_empty),
      .almost_full (rg_afull), .almost_empty (rg_aempty), .count (rg_count),
      .overflow (rg_ovf), .underflow (rg_udf), .clr_err (clr_err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, then returns 1 time unit after the rising edge with inputs idle.
   task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic c);
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      clr_err = c;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      #12;
      checkOutput("reset count", fw_count, 0);
      checkOutput("reset empty", fw_empty, 1);
      checkOutput("reset aempty", fw_aempty, 1);
      checkOutput("reset full", fw_full, 0);
      checkOutput("reset afull", fw_afull, 0);
      checkOutput("reset ovf", fw_ovf, 0);
      checkOutput("reset udf", fw_udf, 0);
      checkOutput("reset fw valid", fw_rd_valid, 0);
      checkOutput("reset rg valid", rg_rd_valid, 0);
      checkOutput("reset rg data", rg_rd_data, 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill with 0x01..0x0D
      for (int i = 1; i <= 13; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
         checkOutput($sformatf("fill count %0d", i), fw_count, i);
         checkOutput($sformatf("fill afull %0d", i), fw_afull, (i >= 11) ? 1 : 0);
         checkOutput($sformatf("fill aempty %0d", i), fw_aempty, (i <= 2) ? 1 : 0);
         checkOutput($sformatf("fill full %0d", i), fw_full, (i == 13) ? 1 : 0);
      end
      checkOutput("fill head", fw_rd_data, 8'h01);
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
      checkOutput("overflow set", fw_ovf, 1);
      checkOutput("overflow count", fw_count, 13);
      checkOutput("overflow rg", rg_ovf, 1);

      // Drain in order
      for (int i = 1; i <= 13; i++) begin
         checkOutput($sformatf("drain head %0d", i), fw_rd_data, i);
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         checkOutput($sformatf("drain rg data %0d", i), rg_rd_data, i);
         checkOutput($sformatf("drain rg valid %0d", i), rg_rd_valid, 1);
      end
      checkOutput("drain empty", fw_empty, 1);
      checkOutput("drain count", fw_count, 0);
      checkOutput("drain fw valid", fw_rd_valid, 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("underflow set", fw_udf, 1);
      checkOutput("underflow rg valid", rg_rd_valid, 0);
      checkOutput("underflow count", fw_count, 0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("clr ovf", fw_ovf, 0);
      checkOutput("clr udf", fw_udf, 0);

      // Pointer wrap: second batch crosses slot 12 -> 0
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("wrap1 head %0d", i), fw_rd_data, 8'h10 + i);
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      end
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      checkOutput("wrap count", fw_count, 8);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("wrap2 head %0d", i), fw_rd_data, 8'hA0 + i);
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         checkOutput($sformatf("wrap2 rg data %0d", i), rg_rd_data, 8'hA0 + i);
      end
      checkOutput("wrap final count", fw_count, 0);

      // Simultaneous read and write at count 5
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         checkOutput($sformatf("both head %0d", k), fw_rd_data, (k < 5) ? (8'hB0 + k) : (8'hC0 + k - 5));
         applyStimulus(1'b1, 8'(8'hC0 + k), 1'b1, 1'b0);
         checkOutput($sformatf("both count %0d", k), fw_count, 5);
      end
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
      checkOutput("refill full", fw_full, 1);
      checkOutput("refill head", fw_rd_data, 8'hCF);
      applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
      checkOutput("full both count", fw_count, 12);
      checkOutput("full both ovf", fw_ovf, 1);
      checkOutput("full both full", fw_full, 0);
      checkOutput("full both rg data", rg_rd_data, 8'hCF);
      for (int j = 0; j < 12; j++) begin
         checkOutput($sformatf("tail head %0d", j), fw_rd_data, (j < 4) ? (8'hD0 + j) : (8'hE0 + j - 4));
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      end
      checkOutput("tail empty", fw_empty, 1);
      checkOutput("tail udf", fw_udf, 0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("tail clr ovf", fw_ovf, 0);

      // Read latency of both modes
      applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
      checkOutput("fwft data", fw_rd_data, 8'h55);
      checkOutput("fwft valid", fw_rd_valid, 1);
      checkOutput("rg valid idle", rg_rd_valid, 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("rg valid pulse", rg_rd_valid, 1);
      checkOutput("rg data pulse", rg_rd_data, 8'h55);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("rg valid drop", rg_rd_valid, 0);
      checkOutput("rg data hold", rg_rd_data, 8'h55);

      // Asynchronous reset in the middle of a cycle
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      checkOutput("pre-reset count", fw_count, 6);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async reset count", fw_count, 0);
      checkOutput("async reset empty", fw_empty, 1);
      checkOutput("async reset rg data", rg_rd_data, 0);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
      checkOutput("post-reset count", fw_count, 1);
      checkOutput("post-reset head", fw_rd_data, 8'h77);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("post-reset rg data", rg_rd_data, 8'h77);
      checkOutput("post-reset empty", fw_empty, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
